acc_mc_controller: RTL

ACC_MC_CONTROLLER -- requirements
Module: acc_mc_controller

---
 rtl/acc_mc_controller_pkg.sv | 58 +++++
 rtl/acc_op_decode.sv | 40 ++++
 rtl/acc_mc_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/acc_mc_controller_pkg.sv
// Shared types and constants for the accumulator multi-cycle controller:
// FSM state encoding, instruction class codes, ALU command codes and the
// decoded-instruction payload passed from acc_op_decode to the FSM.
package acc_mc_controller_pkg;

  localparam int unsigned CLASS_W   = 3;
  localparam int unsigned ALU_CMD_W = 2;
  localparam int unsigned STATE_W   = 4;

  // 12 legal states in a 4-bit register; the 4 spare codes are trapped.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_LDA1   = 4'd3,
    S_LDA2   = 4'd4,
    S_STA1   = 4'd5,
    S_STA2   = 4'd6,
    S_AOP_RD = 4'd7,
    S_AOP_EX = 4'd8,
    S_AOP_WB = 4'd9,
    S_BRANCH = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  // Instruction classes (top three opcode bits)
  localparam logic [CLASS_W-1:0] CLS_LDA = 3'b000;
  localparam logic [CLASS_W-1:0] CLS_STA = 3'b001;
  localparam logic [CLASS_W-1:0] CLS_ADD = 3'b010;
  localparam logic [CLASS_W-1:0] CLS_AND = 3'b011;
  localparam logic [CLASS_W-1:0] CLS_SUB = 3'b100;
  localparam logic [CLASS_W-1:0] CLS_JMP = 3'b101;
  localparam logic [CLASS_W-1:0] CLS_JZ  = 3'b110;
  localparam logic [CLASS_W-1:0] CLS_HLT = 3'b111;

  // ALU commands
  localparam logic [ALU_CMD_W-1:0] ALU_ADD = 2'd0;
  localparam logic [ALU_CMD_W-1:0] ALU_AND = 2'd1;
  localparam logic [ALU_CMD_W-1:0] ALU_SUB = 2'd2;

  // Instruction groups that select the execute path
  typedef enum logic [2:0] {
    GRP_LOAD    = 3'd0,
    GRP_STORE   = 3'd1,
    GRP_ALU     = 3'd2,
    GRP_BRANCH  = 3'd3,
    GRP_HALT    = 3'd4,
    GRP_ILLEGAL = 3'd5
  } group_t;

  // Decoded instruction payload
  typedef struct packed {
    group_t                 group;
    logic [ALU_CMD_W-1:0]   alu_cmd;
    logic                   cond_zero;  // branch taken only when ac_zero
  } decode_t;

endpackage

// File: rtl/acc_op_decode.sv
// Combinational instruction-class decoder.
// Ports:
//   op_class : instruction class (upcode top three bits)
//   dec      : group, ALU command and branch condition for that class
module acc_op_decode
  import acc_mc_controller_pkg::*;
(
  input  logic [CLASS_W-1:0] op_class,
  output decode_t            dec
);

  // Class to group / ALU command map
  always_comb begin
    dec = '{group: GRP_ILLEGAL, alu_cmd: ALU_ADD, cond_zero: 1'b0};
    case (op_class)
      CLS_LDA: dec.group = GRP_LOAD;
      CLS_STA: dec.group = GRP_STORE;
      CLS_ADD: begin
        dec.group   = GRP_ALU;
        dec.alu_cmd = ALU_ADD;
      end
      CLS_AND: begin
        dec.group   = GRP_ALU;
        dec.alu_cmd = ALU_AND;
      end
      CLS_SUB: begin
        dec.group   = GRP_ALU;
        dec.alu_cmd = ALU_SUB;
      end
      CLS_JMP: dec.group = GRP_BRANCH;
      CLS_JZ: begin
        dec.group     = GRP_BRANCH;
        dec.cond_zero = 1'b1;
      end
      CLS_HLT: dec.group = GRP_HALT;
      default: dec.group = GRP_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/acc_mc_controller.sv
// Multi-cycle control FSM for a single-accumulator datapath.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   upcode           : IR opcode field, class in the top three bits
//   mem_ready        : memory completes the current access this cycle
//   ac_zero          : accumulator is zero (JZ condition)
//   resume           : leave HALT
//   pc_write..mem_write : datapath controls, decoded from the state
//   alu_cmd          : ALU operation (0 ADD, 1 AND, 2 SUB)
//   halted           : FSM is in HALT
//   illegal          : sticky, set when the state register held a spare code
module acc_mc_controller
  import acc_mc_controller_pkg::*;
#(
  parameter int unsigned OPW     = 4,
  parameter int unsigned ALUW    = 3,
  parameter int unsigned WAIT_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  upcode,
  input  logic            mem_ready,
  input  logic            ac_zero,
  input  logic            resume,
  output logic            pc_write,
  output logic            pc_load,
  output logic            mem_addr_sel,
  output logic            ac_data_sel,
  output logic            ir_write_sel,
  output logic            mem_read,
  output logic            ir_write,
  output logic            ac_write,
  output logic            ac_read,
  output logic            mem_write,
  output logic [ALUW-1:0] alu_cmd,
  output logic            halted,
  output logic            illegal
);

  state_t               state;
  state_t               state_next;
  logic                 mem_ok;
  logic                 bad_state_c;
  logic [CLASS_W-1:0]   op_class;
  decode_t              dec;

  assign op_class = upcode[OPW-1 -: CLASS_W];

  // Operand bits below the class field are not used by the controller
  if (OPW > CLASS_W) begin : g_low_bits
    logic unused_low;
    assign unused_low = ^upcode[OPW-CLASS_W-1:0];
  end

  // With waiting disabled every memory access completes in one cycle
  assign mem_ok = (WAIT_EN == 0) ? 1'b1 : mem_ready;

  acc_op_decode u_decode (
    .op_class (op_class),
    .dec      (dec)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Sticky trap for spare state codes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal <= 1'b0;
    end else if (bad_state_c) begin
      illegal <= 1'b1;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next   = state;
    bad_state_c  = 1'b0;
    pc_write     = 1'b0;
    pc_load      = 1'b0;
    mem_addr_sel = 1'b0;
    ac_data_sel  = 1'b0;
    ir_write_sel = 1'b0;
    mem_read     = 1'b0;
    ir_write     = 1'b0;
    ac_write     = 1'b0;
    ac_read      = 1'b0;
    mem_write    = 1'b0;
    alu_cmd      = '0;
    halted       = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        // PC must not advance while reset holds the FSM in FETCH
        pc_write = mem_ok & rst;
        if (mem_ok) state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = (dec.group == GRP_HALT) ? S_HALT : S_ADDR;
      end
      S_ADDR: begin
        mem_read     = 1'b1;
        ir_write     = 1'b1;
        ir_write_sel = 1'b1;
        pc_write     = mem_ok;
        if (mem_ok) begin
          case (dec.group)
            GRP_LOAD:   state_next = S_LDA1;
            GRP_STORE:  state_next = S_STA1;
            GRP_ALU:    state_next = S_AOP_RD;
            GRP_BRANCH: state_next = S_BRANCH;
            default:    state_next = S_FETCH;
          endcase
        end
      end
      S_LDA1: begin
        mem_read     = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ok) state_next = S_LDA2;
      end
      S_LDA2: begin
        ac_write   = 1'b1;
        state_next = S_FETCH;
      end
      S_STA1: begin
        ac_read    = 1'b1;
        state_next = S_STA2;
      end
      S_STA2: begin
        mem_write    = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ok) state_next = S_FETCH;
      end
      S_AOP_RD: begin
        ac_read      = 1'b1;
        mem_read     = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ok) state_next = S_AOP_EX;
      end
      S_AOP_EX: begin
        alu_cmd    = ALUW'(dec.alu_cmd);
        state_next = S_AOP_WB;
      end
      S_AOP_WB: begin
        // upcode is not latched; the IR still holds it, so re-decode here
        alu_cmd     = ALUW'(dec.alu_cmd);
        ac_write    = 1'b1;
        ac_data_sel = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        pc_load    = (dec.group == GRP_BRANCH) && (!dec.cond_zero || ac_zero);
        state_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) state_next = S_FETCH;
      end
      default: begin
        bad_state_c = 1'b1;
        state_next  = S_FETCH;
      end
    endcase
  end

endmodule
